// File: rtl/instr_mem_responder.sv
// Instruction-memory responder: one fetch in flight, fixed LATENCY, squash on flush, loader port.
// Optional misaligned-fetch fault reporting is enabled with `define IMEM_ALIGN_CHECK_EN.
module instr_mem_responder #(
  parameter int          DEPTH_LOG2 = 10,
  parameter int          LATENCY    = 2,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_instr,
  output logic [31:0]           rsp_addr,
  input  logic                  flush,
  input  logic                  ld_we,
  input  logic [DEPTH_LOG2-1:0] ld_addr,
  input  logic [31:0]           ld_data,
  output logic                  busy,
`ifdef IMEM_ALIGN_CHECK_EN
  output logic                  rsp_fault,
`endif
  output logic [1:0]            dbg_state
);

  // Handshake: a transfer happens on an edge where valid and ready are both high;
  // rsp_valid/rsp_instr/rsp_addr hold steady until that transfer.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        load;
  logic        accept;
  logic [31:0] mem_rd;
  logic [31:0] instr_d;

  logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];

  assign req_ready = ~flush & ~ld_we &
                     ((state_q == S_IDLE) | ((state_q == S_RESP) & rsp_ready));
  assign accept    = req_valid & req_ready;
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    load    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_WAIT;
          cnt_d   = CNT_INIT;
          addr_d  = req_addr;
        end
      end
      S_WAIT: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == 3'd0) begin
          state_d = S_RESP;
          load    = 1'b1;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_RESP: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (rsp_ready) begin
          if (accept) begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
            addr_d  = req_addr;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Upper address bits are dropped, so fetches wrap modulo the array size.
  assign mem_rd = mem[addr_q[DEPTH_LOG2+1:2]];

`ifdef IMEM_ALIGN_CHECK_EN
  logic fault_d;
  assign fault_d = |addr_q[1:0];
  assign instr_d = fault_d ? NOP_WORD : mem_rd;
`else
  assign instr_d = mem_rd;
`endif

  // The loader only writes while idle so an in-flight fetch never sees a torn image.
  always_ff @(posedge clk) begin
    if (ld_we && !busy) begin
      mem[ld_addr] <= ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 3'd0;
      addr_q    <= 32'd0;
      rsp_instr <= 32'd0;
      rsp_addr  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      if (load) begin
        rsp_instr <= instr_d;
        rsp_addr  <= addr_q;
      end
    end
  end

`ifdef IMEM_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_fault <= 1'b0;
    end else if (load) begin
      rsp_fault <= fault_d;
    end
  end
`endif

endmodule

// File: tb/tb_instr_mem_responder.sv
// Self-checking bench for instr_mem_responder: vector table, corner-case sequences, random fetches.
module tb_instr_mem_responder;

  localparam int          DL   = 10;
  localparam int          LAT  = 2;
  localparam logic [31:0] NOP  = 32'h0000_0000;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            req_valid;
  logic            req_ready;
  logic [31:0]     req_addr;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [31:0]     rsp_instr;
  logic [31:0]     rsp_addr;
  logic            flush;
  logic            ld_we;
  logic [DL-1:0]   ld_addr;
  logic [31:0]     ld_data;
  logic            busy;
  logic            rsp_fault;
  logic [1:0]      dbg_state;

  instr_mem_responder #(.DEPTH_LOG2(DL), .LATENCY(LAT), .NOP_WORD(NOP)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr), .rsp_addr(rsp_addr),
    .flush(flush), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data), .busy(busy),
`ifdef IMEM_ALIGN_CHECK_EN
    .rsp_fault(rsp_fault),
`endif
    .dbg_state(dbg_state)
  );

`ifndef IMEM_ALIGN_CHECK_EN
  assign rsp_fault = 1'b0;
`endif

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [32:0] exp_q[$];               // {fault, instr}
  logic [31:0] ref_mem [0:(1<<DL)-1];

  typedef struct {
    logic [31:0] addr;
    int          hold;
    logic [31:0] exp_instr;
    logic        exp_fault;
  } vec_t;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [32:0] model(input logic [31:0] a);
`ifdef IMEM_ALIGN_CHECK_EN
    if (a[1:0] != 2'b00) return {1'b1, NOP};
`endif
    return {1'b0, ref_mem[a[DL+1:2]]};
  endfunction

  task automatic load(input int idx, input logic [31:0] data);
    ld_we   = 1'b1;
    ld_addr = DL'(idx);
    ld_data = data;
    tick();
    ld_we   = 1'b0;
    ref_mem[idx] = data;
  endtask

  task automatic issue(input logic [31:0] a, input logic [32:0] e, input bit push);
    req_valid = 1'b1;
    req_addr  = a;
    @(negedge clk);
    check32("req_ready_idle", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    if (push) exp_q.push_back(e);
  endtask

  task automatic wait_rsp();
    int cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!rsp_valid && cyc < 20);
    check32("latency", 32'(cyc), 32'(LAT));
  endtask

  task automatic check_rsp(input logic [31:0] a);
    logic [32:0] e;
    check32("rsp_valid", 32'(rsp_valid), 32'd1);
    if (exp_q.size() == 0) begin
      check32("exp_q_empty", 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check32("rsp_instr", rsp_instr, e[31:0]);
    check32("rsp_addr", rsp_addr, a);
`ifdef IMEM_ALIGN_CHECK_EN
    check32("rsp_fault", 32'(rsp_fault), 32'(e[32]));
`endif
  endtask

  task automatic hold_rsp(input int n, input logic [31:0] a, input logic [32:0] e);
    req_valid = 1'b1;
    req_addr  = a + 32'd4;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check32("req_ready_hold", 32'(req_ready), 32'd0);
      tick();
      check32("hold_valid", 32'(rsp_valid), 32'd1);
      check32("hold_instr", rsp_instr, e[31:0]);
      check32("hold_addr", rsp_addr, a);
    end
    req_valid = 1'b0;
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check32("rsp_drop", 32'(rsp_valid), 32'd0);
  endtask

  task automatic fetch(input logic [31:0] a, input int hold, input logic [32:0] e);
    issue(a, e, 1'b1);
    wait_rsp();
    check_rsp(a);
    hold_rsp(hold, a, e);
    consume();
  endtask

  task automatic expect_silence(input string name);
    int seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rsp_valid) seen++;
    end
    check32(name, 32'(seen), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[7];
    logic [32:0] e;

    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
    flush = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (3) tick();
    check32("reset_valid", 32'(rsp_valid), 32'd0);
    check32("reset_instr", rsp_instr, 32'd0);
    check32("reset_addr", rsp_addr, 32'd0);
    check32("reset_busy", 32'(busy), 32'd0);
`ifdef IMEM_ALIGN_CHECK_EN
    check32("reset_fault", 32'(rsp_fault), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check32("idle_ready", 32'(req_ready), 32'd1);

    load(0, 32'h0BAD_0000);
    load(1, 32'h1111_0001);
    load(3, 32'h2008_0005);
    load(4, 32'hAAAA_0004);
    load(5, 32'h5555_0005);
    load(8, 32'h8888_0008);
    load(9, 32'h9999_0009);

    vecs[0] = '{32'h0000_000C, 0, 32'h2008_0005, 1'b0};
    vecs[1] = '{32'h0000_0004, 1, 32'h1111_0001, 1'b0};
    vecs[2] = '{32'h0000_1004, 0, 32'h1111_0001, 1'b0};
    vecs[3] = '{32'hFFFF_F00C, 2, 32'h2008_0005, 1'b0};
`ifdef IMEM_ALIGN_CHECK_EN
    vecs[4] = '{32'h0000_0006, 0, NOP, 1'b1};
    vecs[5] = '{32'h0000_0002, 1, NOP, 1'b1};
`else
    vecs[4] = '{32'h0000_0006, 0, 32'h1111_0001, 1'b0};
    vecs[5] = '{32'h0000_0002, 1, 32'h0BAD_0000, 1'b0};
`endif
    vecs[6] = '{32'h0000_0014, 0, 32'h5555_0005, 1'b0};

    for (int i = 0; i < 7; i++) begin
      fetch(vecs[i].addr, vecs[i].hold, {vecs[i].exp_fault, vecs[i].exp_instr});
    end

    // Long hold, then back-to-back accept in the consume cycle.
    e = {1'b0, 32'h2008_0005};
    issue(32'h0000_000C, e, 1'b1);
    wait_rsp();
    check_rsp(32'h0000_000C);
    hold_rsp(5, 32'h0000_000C, e);
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_addr  = 32'h0000_0010;
    @(negedge clk);
    check32("b2b_ready", 32'(req_ready), 32'd1);
    tick();
    exp_q.push_back({1'b0, 32'hAAAA_0004});
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    check32("b2b_valid_low", 32'(rsp_valid), 32'd0);
    wait_rsp();
    check_rsp(32'h0000_0010);
    consume();

    // Flush one cycle after accept squashes the fetch.
    issue(32'h0000_0020, '0, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    check32("flush_ready", 32'(req_ready), 32'd0);
    tick();
    flush = 1'b0;
    check32("flush_idle", 32'(busy), 32'd0);
    expect_silence("flush_no_rsp");
    fetch(32'h0000_0024, 0, {1'b0, 32'h9999_0009});

    // Loader write while busy is dropped.
    issue(32'h0000_000C, {1'b0, 32'h2008_0005}, 1'b1);
    ld_we = 1'b1; ld_addr = DL'(5); ld_data = 32'hDEAD_BEEF;
    wait_rsp();
    ld_we = 1'b0;
    check_rsp(32'h0000_000C);
    consume();
    fetch(32'h0000_0014, 0, {1'b0, 32'h5555_0005});

    // Reset in WAIT drops the fetch; array contents survive.
    issue(32'h0000_0010, '0, 1'b0);
    rst_n = 1'b0;
    #1;
    check32("rst_valid", 32'(rsp_valid), 32'd0);
    check32("rst_busy", 32'(busy), 32'd0);
    check32("rst_instr", rsp_instr, 32'd0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    expect_silence("rst_no_rsp");
    fetch(32'h0000_000C, 0, {1'b0, 32'h2008_0005});

    // Randomized loads and fetches against the array model.
    for (int i = 16; i < 32; i++) load(i, $urandom);
    for (int k = 0; k < 60; k++) begin
      int idx;
      logic [31:0] a;
      idx = $urandom_range(16, 31);
      if ($urandom_range(0, 3) == 0) begin
        load(idx, $urandom);
      end else begin
        a = $urandom;
        a[DL+1:2] = DL'(idx);
        fetch(a, $urandom_range(0, 2), model(a));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
